// File: rtl/lut_writer_pkg.sv
// lut_writer_pkg: shared widths, writer states and the select-to-bit placement of the mux4 truth table
package lut_writer_pkg;
  localparam int SEL_W = 4;
  localparam int LUT_W = 1 << SEL_W;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} lut_wr_state_t;
  function automatic logic [SEL_W-1:0] lut_pos(input logic [SEL_W-1:0] sel);
    return 4'd15 - {sel[0], sel[1], sel[2], sel[3]};
  endfunction
endpackage

// File: rtl/lut_demux.sv
// lut_demux: one-hot per-bit write enable for the table entry addressed by sel
module lut_demux
  import lut_writer_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [LUT_W-1:0] we
);
  always_comb begin
    we = '0;
    we[lut_pos(sel)] = en;
  end
endmodule

// File: rtl/lut_writer.sv
// lut_writer: streamed/single-entry writer for the mux4 truth table; LUT_WRITER_SHADOW_EN makes streamed loads commit atomically
module lut_writer
  import lut_writer_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   ser_valid,
  input  logic                   ser_data,
  output logic                   ser_ready,
  input  logic                   wr_valid,
  input  logic [SEL_W-1:0]       wr_sel,
  input  logic                   wr_data,
  output logic                   wr_ready,
  output logic [(1<<SEL_W)-1:0]  lut,
  output logic                   busy,
  output logic                   done
);
  localparam int LW = 1 << SEL_W;
  lut_wr_state_t state;
  logic [SEL_W-1:0] cnt;
  logic ser_acc, wr_acc, bit_d;
  logic [LW-1:0] we, lut_nx;
  assign ser_ready = state == LOAD && !load_start;
  assign wr_ready  = state == IDLE && !load_start;
  assign ser_acc   = ser_ready && ser_valid;
  assign wr_acc    = wr_ready && wr_valid;
  assign bit_d     = ser_acc ? ser_data : wr_data;
  lut_demux u_demux (
    .sel(ser_acc ? cnt : wr_sel),
    .en (ser_acc || wr_acc),
    .we (we)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load_start) begin
          state <= LOAD;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      end else if (state == LOAD) begin
        if (load_start) cnt <= '0;
        else if (ser_valid && cnt == '1) begin
          state <= COMMIT;
          done  <= 1'b1;
        end else if (ser_valid) cnt <= cnt + 1'b1;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
`ifdef LUT_WRITER_SHADOW_EN
  logic [LW-1:0] shadow, shadow_nx;
  assign shadow_nx = (shadow & ~we) | (we & {LW{bit_d}});
  assign lut_nx    = (lut & ~we) | (we & {LW{bit_d}});
  // the last streamed bit is merged on the fly so lut flips in the same edge that raises done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      lut    <= '0;
    end else begin
      shadow <= shadow_nx;
      if (wr_acc) lut <= lut_nx;
      else if (ser_acc && cnt == '1) lut <= shadow_nx;
    end
`else
  assign lut_nx = (lut & ~we) | (we & {LW{bit_d}});
  always_ff @(posedge clk or posedge rst)
    if (rst) lut <= '0;
    else lut <= lut_nx;
`endif
endmodule

// File: tb/tb_lut_writer.sv
// tb_lut_writer: select-level reference model with per-cycle compare, directed scenarios and random traffic
module tb_lut_writer;
  import lut_writer_pkg::*;
  logic clk = 0, rst = 0, load_start = 0, ser_valid = 0, ser_data = 0, wr_valid = 0, wr_data = 0;
  logic [3:0] wr_sel = 0;
  logic ser_ready, wr_ready, busy, done;
  logic [15:0] lut;
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int m_phase = 0, m_cnt = 0;
  bit m_tab[16], m_sh[16];

  lut_writer dut (
    .clk(clk), .rst(rst), .load_start(load_start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(wr_ready), .lut(lut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  // what the select tree returns for sel = s: bit 15 - bitreverse(s)
  function automatic bit mux4(input logic [15:0] l, input logic [3:0] s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = s[3-i];
    return l[15-r];
  endfunction

  function automatic logic [15:0] readback(input logic [15:0] l);
    logic [15:0] v;
    for (int s = 0; s < 16; s++) v[s] = mux4(l, 4'(s));
    return v;
  endfunction

  function automatic logic [15:0] model_lut();
    logic [15:0] v;
    v = '0;
    for (int s = 0; s < 16; s++) v[lut_pos(4'(s))] = m_tab[s];
    return v;
  endfunction

  // reference model kept per select value
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_phase = 0;
      m_cnt = 0;
      for (int s = 0; s < 16; s++) begin m_tab[s] = 0; m_sh[s] = 0; end
    end else if (m_phase == 0) begin
      if (load_start) begin m_phase = 1; m_cnt = 0; end
      else if (wr_valid) begin m_tab[wr_sel] = wr_data; m_sh[wr_sel] = wr_data; end
    end else if (m_phase == 1) begin
      if (load_start) m_cnt = 0;
      else if (ser_valid) begin
        m_sh[m_cnt] = ser_data;
`ifndef LUT_WRITER_SHADOW_EN
        m_tab[m_cnt] = ser_data;
`endif
        if (m_cnt == 15) begin
          m_phase = 2;
`ifdef LUT_WRITER_SHADOW_EN
          for (int s = 0; s < 16; s++) m_tab[s] = m_sh[s];
`endif
        end else m_cnt++;
      end
    end else m_phase = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("ser_ready", ser_ready, m_phase == 1 && !load_start);
    chk("wr_ready", wr_ready, m_phase == 0 && !load_start);
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == 2);
    chk("lut", lut, model_lut());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1;
    tick();
    load_start = 0;
  endtask

  task automatic stream(input logic [15:0] pat, input bit gaps, output int first, output int dcyc);
    first = -1;
    dcyc = -1;
    for (int i = 0; i < 16; i++) begin
      ser_valid = 1;
      ser_data = pat[i];
      @(negedge clk);
      if (first < 0) first = cyc;
      tick();
      if (gaps && i < 15) begin ser_valid = 0; tick(); end
    end
    ser_valid = 0;
    for (int k = 0; k < 40 && dcyc < 0; k++) begin
      @(negedge clk);
      if (done) dcyc = cyc; else tick();
    end
    if (dcyc >= 0) tick();
  endtask

  int f, d, dc0;
  initial begin
    #1 rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_lut", lut, 16'h0000);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_ser_ready", ser_ready, 0);
    chk("rst_busy", busy, 0);
    tick();
    wr_valid = 1; wr_sel = 1; wr_data = 1;
    tick();
    wr_valid = 0;
    @(negedge clk);
    chk("wr1_lut", lut, 16'h0080);
    chk("wr1_mux", readback(lut), 16'h0002);
    tick();
    start_load();
    stream(16'h6996, 0, f, d);
    chk("lat_contig", d - f, 16);
    chk("lut_6996", lut, 16'h6996);
    chk("mux_6996", readback(lut), 16'h6996);
    start_load();
    stream(16'h3C5A, 1, f, d);
    chk("lat_gaps", d - f, 31);
    chk("mux_3c5a", readback(lut), 16'h3C5A);
    start_load();
    wr_valid = 1; wr_sel = 4'd15; wr_data = 0;
    for (int i = 0; i < 7; i++) begin
      ser_valid = 1; ser_data = 1'($urandom);
      @(negedge clk);
      chk("wr_ready_load", wr_ready, 0);
      tick();
    end
    wr_valid = 0;
    load_start = 1; ser_valid = 1;
    @(negedge clk);
    chk("restart_ser_ready", ser_ready, 0);
    tick();
    load_start = 0;
    stream(16'h1234, 0, f, d);
    chk("lat_restart", d - f, 16);
    chk("mux_1234", readback(lut), 16'h1234);
    for (int s = 0; s < 16; s++) begin
      wr_valid = 1; wr_sel = 4'(s); wr_data = 1;
      tick();
    end
    wr_valid = 0;
    @(negedge clk);
    chk("fill_ffff", lut, 16'hFFFF);
    tick();
    start_load();
    for (int i = 0; i < 16; i++) begin
      ser_valid = 1; ser_data = 0;
      @(negedge clk);
      if (i == 8) begin
`ifdef LUT_WRITER_SHADOW_EN
        chk("shadow_hold", lut, 16'hFFFF);
`else
        chk("partial_clear", readback(lut), 16'hFF00);
`endif
      end
      tick();
    end
    ser_valid = 0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_lut", lut, 16'h0000);
    tick();
    start_load();
    for (int i = 0; i < 10; i++) begin
      ser_valid = 1; ser_data = 1;
      tick();
    end
    ser_valid = 0;
    dc0 = done_cnt;
    rst = 1;
    #1;
    chk("abort_lut", lut, 16'h0000);
    chk("abort_busy", busy, 0);
    tick();
    rst = 0;
    repeat (20) tick();
    chk("abort_no_done", done_cnt - dc0, 0);
    for (int i = 0; i < 3000; i++) begin
      load_start = $urandom_range(0, 19) == 0;
      ser_valid = 1'($urandom);
      ser_data = 1'($urandom);
      wr_valid = $urandom_range(0, 3) == 0;
      wr_sel = 4'($urandom);
      wr_data = 1'($urandom);
      rst = $urandom_range(0, 499) == 0;
      tick();
    end
    rst = 0; load_start = 0; ser_valid = 0; wr_valid = 0;
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
